// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the data-cache controller: bus command encodings,
// memory-ticket sizing and cache-line address helpers.
package dcache_ctrl_pkg;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'b00,
        BUS_LOAD  = 2'b01,
        BUS_STORE = 2'b10
    } bus_cmd_e;

    localparam int MEM_TAG_W    = 4;
    localparam int NUM_MEM_TAGS = 15;
    localparam int LINE_OFF_W   = 3;
    localparam int LINE_ADDR_W  = 64 - LINE_OFF_W;

    typedef logic [MEM_TAG_W-1:0]   mem_tag_t;
    typedef logic [LINE_ADDR_W-1:0] line_addr_t;

    function automatic line_addr_t line_of(input logic [63:0] addr);
        return addr[63:LINE_OFF_W];
    endfunction

    function automatic logic [63:0] line_base(input logic [63:0] addr);
        return {addr[63:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_mem.sv
// Direct-mapped line store: one combinational read port and two ordered
// write ports (fill first, then store) with invalidate-all on reset.
module dcache_mem
    import dcache_ctrl_pkg::*;
#(
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  line_addr_t       rd_line_i,
    output logic             rd_hit_o,
    output logic [63:0]      rd_data_o,
    input  logic             fill_en_i,
    input  line_addr_t       fill_line_i,
    input  logic [63:0]      fill_data_i,
    input  logic             st_en_i,
    input  line_addr_t       st_line_i,
    input  logic [63:0]      st_data_i
);

    localparam int NUM_LINES = 2**IDX_W;
    localparam int TAG_W     = LINE_ADDR_W - IDX_W;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0] tag_t;

    logic [NUM_LINES-1:0] valid_q;
    tag_t                 tag_q  [NUM_LINES];
    logic [63:0]          data_q [NUM_LINES];

    idx_t rd_idx, fill_idx, st_idx;
    tag_t rd_tag, fill_tag, st_tag;
    logic st_hit;

    assign {rd_tag, rd_idx}     = rd_line_i;
    assign {fill_tag, fill_idx} = fill_line_i;
    assign {st_tag, st_idx}     = st_line_i;

    assign rd_hit_o  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_data_o = data_q[rd_idx];

    // A store is judged against the line as it stands after a same-edge fill.
    // NOTE: always_comb assigns every output first so no latch is inferred.
    always_comb begin
        st_hit = valid_q[st_idx] && (tag_q[st_idx] == st_tag);
        if (fill_en_i && (fill_idx == st_idx)) begin
            st_hit = (fill_tag == st_tag);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (fill_en_i) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (fill_en_i) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_data_i;
        end
        if (st_en_i && st_hit) begin
            data_q[st_idx] <= st_data_i;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// LSQ-facing data-cache controller: same-cycle load hits, miss/store
// forwarding to memory, and a ticket-indexed miss table for returning fills.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int IDX_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  bus_cmd_e        lsq2mem_command,
    input  logic [63:0]     lsq2mem_addr,
    input  logic [63:0]     lsq2mem_data,
    output mem_tag_t        mem2lsq_response,
    output logic            dcache2lsq_valid,
    output mem_tag_t        dcache2lsq_tag,
    output logic [63:0]     dcache2lsq_data,
    output bus_cmd_e        proc2mem_command,
    output logic [63:0]     proc2mem_addr,
    output logic [63:0]     proc2mem_data,
    input  mem_tag_t        mem2proc_response,
    input  logic [63:0]     mem2proc_data,
    input  mem_tag_t        mem2proc_tag
);

    localparam int TBL_SIZE = 2**MEM_TAG_W;

    // Entry 0 is never allocated, so ticket 0 always reads as not pending.
    logic [TBL_SIZE-1:0] pending_q, pending_d;
    logic [TBL_SIZE-1:0] nofill_q, nofill_d;
    line_addr_t          pend_addr_q [TBL_SIZE];

    line_addr_t  req_line;
    logic        fill;
    logic        alloc_en;
    logic        st_fwd;
    logic        rd_hit;
    logic [63:0] rd_data;

    assign req_line      = line_of(lsq2mem_addr);
    assign proc2mem_addr = line_base(lsq2mem_addr);
    assign proc2mem_data = lsq2mem_data;

    assign fill     = !reset && (mem2proc_tag != '0) && pending_q[mem2proc_tag];
    assign alloc_en = (proc2mem_command == BUS_LOAD) && (mem2proc_response != '0);
    assign st_fwd   = (proc2mem_command == BUS_STORE);

    dcache_mem #(.IDX_W(IDX_W)) u_mem (
        .clk         (clk),
        .reset       (reset),
        .rd_line_i   (req_line),
        .rd_hit_o    (rd_hit),
        .rd_data_o   (rd_data),
        .fill_en_i   (fill && !nofill_q[mem2proc_tag]),
        .fill_line_i (pend_addr_q[mem2proc_tag]),
        .fill_data_i (mem2proc_data),
        .st_en_i     (st_fwd),
        .st_line_i   (req_line),
        .st_data_i   (lsq2mem_data)
    );

    // A fill owns the LSQ data bus, so a concurrent load is neither hit nor forwarded.
    always_comb begin
        dcache2lsq_valid = 1'b0;
        dcache2lsq_tag   = '0;
        dcache2lsq_data  = '0;
        proc2mem_command = BUS_NONE;
        mem2lsq_response = '0;
        if (!reset) begin
            if (fill) begin
                dcache2lsq_valid = 1'b1;
                dcache2lsq_tag   = mem2proc_tag;
                dcache2lsq_data  = mem2proc_data;
            end
            case (lsq2mem_command)
                BUS_LOAD: begin
                    if (!fill) begin
                        if (rd_hit) begin
                            dcache2lsq_valid = 1'b1;
                            dcache2lsq_data  = rd_data;
                        end else begin
                            proc2mem_command = BUS_LOAD;
                            mem2lsq_response = mem2proc_response;
                        end
                    end
                end
                BUS_STORE: begin
                    proc2mem_command = BUS_STORE;
                    mem2lsq_response = mem2proc_response;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pending_d = pending_q;
        nofill_d  = nofill_q;
        if (fill) begin
            pending_d[mem2proc_tag] = 1'b0;
        end
        if (alloc_en) begin
            pending_d[mem2proc_response] = 1'b1;
            nofill_d[mem2proc_response]  = 1'b0;
        end
        // A store to a line with an outstanding miss makes that fill stale.
        if (st_fwd) begin
            for (int t = 1; t <= NUM_MEM_TAGS; t++) begin
                if (pending_q[t] && (pend_addr_q[t] == req_line)) begin
                    nofill_d[t] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            nofill_q  <= '0;
        end else begin
            pending_q <= pending_d;
            nofill_q  <= nofill_d;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_en) begin
            pend_addr_q[mem2proc_response] <= req_line;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_en) begin
            assert (!pending_q[mem2proc_response])
                else $error("memory ticket %0d issued while still pending", mem2proc_response);
        end
    end

endmodule
